stream_demux_router: RTL and testbench

Parametrised 1-to-N streaming demultiplexer with valid/ready handshakes. It routes each input beat to one output channel chosen by in_sel, or to all enabled channels in broadcast mode. Each channel has a one-entry registered output slot, so input-to-output latency is 1 cycle and backpressure is per channel. It sits between a single producer and N independent consumers in the datapath, and drops beats addressed to disabled or out-of-range channels.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 52 +++++
 rtl/stream_demux_router.sv | 99 +++++++++
 tb/tb_stream_demux_router.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared defaults and select range helper for the stream demux router
//
// Purpose : default widths for stream_demux_router and a range check for
//           the unicast select.
// Contents: DEF_DATA_W, DEF_SEL_W, DEF_N_OUT, DEF_CNT_W, sel_in_range()
package stream_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_N_OUT  = 16;
  localparam int DEF_CNT_W  = 8;

  // True when sel addresses an existing channel.
  function automatic logic sel_in_range(input int sel, input int n_out);
    return (sel >= 0) && (sel < n_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - single-entry registered output slot with valid/ready
//
// Purpose : one-deep register slice for one demux channel. A write while the
//           consumer pops reloads the slot, so it sustains one beat per cycle.
// Ports   : clk, rst_n       clock, async active-low reset
//           wr_en, wr_data  load request and payload
//           rd_ready        consumer ready
//           valid, data     slot contents
//           free            slot can take a write this cycle
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end else if (rd_ready) begin
      // Pop without write empties the slot; data keeps its last value.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign free  = !valid_q || rd_ready;

endmodule

// File: rtl/stream_demux_router.sv
// rtl/stream_demux_router.sv - 1-to-N valid/ready stream demux with broadcast and drop counting
//
// Purpose : routes each input beat to the channel named by in_sel, or to
//           every enabled channel when in_bcast is set. Beats with no valid
//           target are accepted and dropped, pulsing drop_pulse and bumping
//           the saturating drop_cnt.
// Ports   : clk, rst_n                         clock, async active-low reset
//           in_valid/in_ready/in_data/in_sel  input stream
//           in_bcast                          broadcast to all enabled channels
//           ch_en                             per-channel enable
//           out_valid/out_ready/out_data      per-channel output streams
//           drop_pulse, drop_cnt              drop reporting
module stream_demux_router
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic [N_OUT-1:0]        ch_en,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    drop_pulse,
  output logic [CNT_W-1:0]        drop_cnt
);

  logic [N_OUT-1:0] uni_hit;
  logic [N_OUT-1:0] tgt;
  logic [N_OUT-1:0] slot_free;
  logic [N_OUT-1:0] wr_en;
  logic             tgt_any;
  logic             accept;
  logic             drop;

  logic             drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // One-hot decode of in_sel; stays all-zero when in_sel is out of range.
  always_comb begin
    uni_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      uni_hit[k] = sel_in_range(int'(in_sel), N_OUT) && (in_sel == SEL_W'(k));
    end
  end

  assign tgt     = in_bcast ? ch_en : (uni_hit & ch_en);
  assign tgt_any = |tgt;

  // All targets must be free so a broadcast is never partially delivered.
  // With no target the beat is swallowed, hence ready is forced high.
  assign in_ready = !tgt_any || (&(slot_free | ~tgt));
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !tgt_any;
  assign wr_en    = accept ? tgt : '0;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[k]),
      .wr_data  (in_data),
      .rd_ready (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W]),
      .free     (slot_free[k])
    );
  end

  always_comb begin
    drop_pulse_d = drop;
    drop_cnt_d   = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// tb/tb_stream_demux_router.sv - directed self-checking bench for stream_demux_router
module tb_stream_demux_router;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance: 16 channels, 8-bit counter
  logic         m_valid = 1'b0, m_ready, m_bcast = 1'b0, m_dp;
  logic [7:0]   m_data = '0, m_cnt;
  logic [3:0]   m_sel = '0;
  logic [15:0]  m_en = '1, m_ovalid, m_oready = '1;
  logic [127:0] m_odata;

  // 12-channel instances sharing inputs: 8-bit and 2-bit counters
  logic         n_valid = 1'b0, n_bcast = 1'b0, a_ready, b_ready, a_dp, b_dp;
  logic [7:0]   n_data = '0, a_cnt;
  logic [1:0]   b_cnt;
  logic [3:0]   n_sel = '0;
  logic [11:0]  n_en = '1, n_oready = '1, a_ovalid, b_ovalid;
  logic [95:0]  a_odata, b_odata;

  stream_demux_router #(.DATA_W(8), .SEL_W(4), .N_OUT(16), .CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_ready(m_ready), .in_data(m_data),
    .in_sel(m_sel), .in_bcast(m_bcast), .ch_en(m_en), .out_valid(m_ovalid),
    .out_ready(m_oready), .out_data(m_odata), .drop_pulse(m_dp), .drop_cnt(m_cnt));

  stream_demux_router #(.DATA_W(8), .SEL_W(4), .N_OUT(12), .CNT_W(8)) u_n12 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(a_ready), .in_data(n_data),
    .in_sel(n_sel), .in_bcast(n_bcast), .ch_en(n_en), .out_valid(a_ovalid),
    .out_ready(n_oready), .out_data(a_odata), .drop_pulse(a_dp), .drop_cnt(a_cnt));

  stream_demux_router #(.DATA_W(8), .SEL_W(4), .N_OUT(12), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(b_ready), .in_data(n_data),
    .in_sel(n_sel), .in_bcast(n_bcast), .ch_en(n_en), .out_valid(b_ovalid),
    .out_ready(n_oready), .out_data(b_odata), .drop_pulse(b_dp), .drop_cnt(b_cnt));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int k);
    return m_odata[k*8 +: 8];
  endfunction

  typedef struct {
    logic [3:0]  sel;
    logic        bcast;
    logic [15:0] en;
    logic [15:0] rdy;
    logic [7:0]  data;
    logic        exp_rdy;
    logic [15:0] exp_vld;
    logic        exp_drop;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // unicast sweep, then broadcast to 0/1, then a disabled-channel drop, then sel 15
    for (int k = 0; k < 16; k++)
      tbl.push_back('{4'(k), 1'b0, 16'hFFFF, 16'hFFFF, 8'hA5, 1'b1, 16'(1 << k), 1'b0});
    tbl.push_back('{4'd9, 1'b1, 16'h0003, 16'hFFFF, 8'h5A, 1'b1, 16'h0003, 1'b0});
    tbl.push_back('{4'd4, 1'b0, 16'hFFEF, 16'hFFFF, 8'hC3, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{4'd15, 1'b0, 16'hFFFF, 16'hFFFF, 8'h96, 1'b1, 16'h8000, 1'b0});

    // reset state
    #2;
    chk("rst_out_valid", m_ovalid, 16'h0);
    chk("rst_out_data", m_odata, 128'h0);
    chk("rst_drop_pulse", m_dp, 1'b0);
    chk("rst_drop_cnt", m_cnt, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      m_valid = 1'b1; m_sel = tbl[i].sel; m_bcast = tbl[i].bcast;
      m_en = tbl[i].en; m_oready = tbl[i].rdy; m_data = tbl[i].data;
      #1 chk($sformatf("vec%0d_in_ready", i), m_ready, tbl[i].exp_rdy);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), m_ovalid, tbl[i].exp_vld);
      chk($sformatf("vec%0d_drop_pulse", i), m_dp, tbl[i].exp_drop);
      for (int k = 0; k < 16; k++)
        if (tbl[i].exp_vld[k]) chk($sformatf("vec%0d_data%0d", i, k), mbyte(k), tbl[i].data);
    end
    m_valid = 1'b0; m_bcast = 1'b0; m_en = '1; m_oready = '1;
    @(negedge clk);
    chk("table_drop_cnt", m_cnt, 8'd1);

    // backpressure on channel 3
    m_oready = 16'hFFF7; m_valid = 1'b1; m_sel = 4'd3; m_data = 8'h11;
    #1 chk("bp_first_ready", m_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("bp_first_valid", m_ovalid[3], 1'b1);
    chk("bp_first_data", mbyte(3), 8'h11);
    m_data = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp_stall_ready%0d", c), m_ready, 1'b0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("bp_stall_data%0d", c), mbyte(3), 8'h11);
    end
    m_oready = '1;
    #1 chk("bp_release_ready", m_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    m_valid = 1'b0;
    chk("bp_second_valid", m_ovalid[3], 1'b1);
    chk("bp_second_data", mbyte(3), 8'h22);
    @(negedge clk);
    chk("bp_drained", m_ovalid, 16'h0);

    // broadcast blocked by full channel 5
    m_oready = 16'hFFDF; m_valid = 1'b1; m_sel = 4'd5; m_data = 8'h55;
    @(posedge clk); @(negedge clk);
    m_bcast = 1'b1; m_en = 16'h00F0; m_data = 8'h3C;
    #1 chk("bc_blocked_ready", m_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("bc_blocked_valid", m_ovalid, 16'h0020);
    chk("bc_blocked_data5", mbyte(5), 8'h55);
    m_oready = '1;
    #1 chk("bc_release_ready", m_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    m_valid = 1'b0; m_bcast = 1'b0; m_en = '1;
    chk("bc_valid", m_ovalid, 16'h00F0);
    for (int k = 4; k < 8; k++) chk($sformatf("bc_data%0d", k), mbyte(k), 8'h3C);
    @(negedge clk);

    // streaming throughput on channel 7
    m_sel = 4'd7; m_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      m_data = 8'(i);
      #1 chk($sformatf("stream_ready%0d", i), m_ready, 1'b1);
      if (i > 1) begin
        chk($sformatf("stream_valid%0d", i), m_ovalid[7], 1'b1);
        chk($sformatf("stream_data%0d", i), mbyte(7), 8'(i - 1));
      end
      @(posedge clk); @(negedge clk);
    end
    m_valid = 1'b0;
    chk("stream_last", mbyte(7), 8'd8);

    // drops on the 12-channel instances
    for (int d = 0; d < 5; d++) begin
      n_valid = 1'b1;
      case (d)
        0: begin n_sel = 4'd13; n_bcast = 1'b0; n_en = '1; end
        1: begin n_sel = 4'd2;  n_bcast = 1'b0; n_en = 12'hFFB; end
        2: begin n_sel = 4'd0;  n_bcast = 1'b1; n_en = 12'h000; end
        3: begin n_sel = 4'd12; n_bcast = 1'b0; n_en = '1; end
        default: begin n_sel = 4'd15; n_bcast = 1'b0; n_en = '1; end
      endcase
      #1 chk($sformatf("drop%0d_ready", d), {a_ready, b_ready}, 2'b11);
      @(posedge clk); @(negedge clk);
      n_valid = 1'b0;
      chk($sformatf("drop%0d_pulse", d), {a_dp, b_dp}, 2'b11);
      chk($sformatf("drop%0d_valid", d), {a_ovalid, b_ovalid}, 24'h0);
      @(negedge clk);
      chk($sformatf("drop%0d_pulse_end", d), {a_dp, b_dp}, 2'b00);
      if (d == 2) chk("drop3_cnt", {a_cnt, 6'd0, b_cnt}, {8'd3, 6'd0, 2'd3});
    end
    chk("drop5_cnt12", a_cnt, 8'd5);
    chk("drop5_cnt_sat", b_cnt, 2'd3);

    // reset mid-stream with slots 1 and 9 full
    m_oready = 16'h0000; m_en = '1; m_valid = 1'b1; m_sel = 4'd1; m_data = 8'h77;
    @(posedge clk); @(negedge clk);
    m_sel = 4'd9; m_data = 8'h99;
    @(posedge clk); @(negedge clk);
    m_valid = 1'b0;
    chk("pre_rst_valid", m_ovalid, 16'h0202);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_ovalid, 16'h0);
    chk("mid_rst_data", m_odata, 128'h0);
    chk("mid_rst_cnt", m_cnt, 8'h0);
    @(negedge clk);
    rst_n = 1'b1; m_oready = '1; m_valid = 1'b1; m_sel = 4'd1; m_data = 8'h42;
    #1 chk("post_rst_ready", m_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    m_valid = 1'b0;
    chk("post_rst_valid", m_ovalid, 16'h0002);
    chk("post_rst_data", mbyte(1), 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
